random_lfsr_bank: RTL and testbench

- Parametrised bank of independent Fibonacci LFSR cells. Bit 0 of every cell is gathered into a CHANNELS-wide raw word.
- Adds features the previous generation lacked: configurable LFSR length, seed reload, warm-up discard, and a req/valid draw interface.
- The draw interface returns a uniformly distributed value below LIMIT using rejection sampling.
- Used by game logic, e.g. mole position and delay selection, wherever a bounded random number is needed on request.

---
 rtl/random_lfsr_bank.sv | 184 ++++++++++++++++++
 tb/tb_random_lfsr_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/random_lfsr_bank.sv
// random_lfsr_bank: bank of Fibonacci LFSR cells with warm-up,
// seed reload and a bounded req/valid draw port (rejection sampling).
// Ports:
//   clock, resetn      rising-edge clock, sync active-low reset
//   seeds, seed_load   per-cell seeds, reload + restart warm-up
//   enable             free-run stepping while idle
//   req                draw request, taken only while idle
//   busy               state is not IDLE
//   data, data_valid   drawn value (held), one-cycle update pulse
//   timeout            fallback value used, pulses with data_valid
module random_lfsr_bank #(
  parameter int CHANNELS  = 8,
  parameter int LFSR_W    = 8,
  parameter int WARMUP    = 16,
  parameter int LIMIT     = 256,
  parameter int MAX_TRIES = 15
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [CHANNELS*LFSR_W-1:0] seeds,
  input  logic                       seed_load,
  input  logic                       enable,
  input  logic                       req,
  output logic                       busy,
  output logic [CHANNELS-1:0]        data,
  output logic                       data_valid,
  output logic                       timeout
);

  if (LFSR_W != 8 && LFSR_W != 16 && LFSR_W != 32) begin : g_bad_w
    $error("random_lfsr_bank: LFSR_W must be 8, 16 or 32");
  end

  localparam logic [31:0] TAP32 =
    (LFSR_W == 8)  ? 32'h0000_00B8 :
    (LFSR_W == 16) ? 32'h0000_B400 :
                     32'h8020_0003;
  localparam logic [LFSR_W-1:0] TAPS = TAP32[LFSR_W-1:0];

  localparam int LB   = $clog2(LIMIT);
  localparam bit POW2 = (LIMIT == (1 << LB));

  localparam logic [CHANNELS:0] LIM_V = (CHANNELS+1)'(LIMIT);
  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);
  localparam logic [7:0] TRY_LAST  = 8'(MAX_TRIES - 1);

  // Fallback mask: keep the low clog2(LIMIT) bits. For a
  // power-of-two LIMIT that is already in range; otherwise the
  // top kept bit is also dropped so the value is below LIMIT.
  function automatic logic [CHANNELS-1:0] fb_mask();
    logic [CHANNELS-1:0] m;
    m = '0;
    for (int b = 0; b < CHANNELS; b++) begin
      if (b < LB) m[b] = 1'b1;
    end
    if (!POW2) m[LB-1] = 1'b0;
    return m;
  endfunction

  localparam logic [CHANNELS-1:0] FB_MASK = fb_mask();

  typedef enum logic [1:0] {
    S_WARM,
    S_IDLE,
    S_DRAW
  } state_e;

  typedef logic [CHANNELS-1:0][LFSR_W-1:0] cells_t;

  state_e              state_q, state_d;
  logic [7:0]          warm_q, warm_d;
  logic [7:0]          try_q, try_d;
  cells_t              cells_q, cells_d;
  cells_t              cells_step;
  cells_t              seed_sub;
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] data_q, data_d;
  logic                dv_q, dv_d;
  logic                to_q, to_d;
  logic                busy_q, busy_d;
  logic                in_range;

  // Zero seeds would lock a cell forever; swap in i+1.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      seed_sub[i] = seeds[i*LFSR_W +: LFSR_W];
      if (seed_sub[i] == '0) seed_sub[i] = LFSR_W'(i + 1);
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cells_step[i] = {cells_q[i][LFSR_W-2:0],
                       ^(cells_q[i] & TAPS)};
      raw[i] = cells_q[i][0];
    end
  end

  assign in_range = ({1'b0, raw} < LIM_V);

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    try_d   = try_q;
    cells_d = cells_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    to_d    = 1'b0;
    if (seed_load) begin
      cells_d = seed_sub;
      state_d = S_WARM;
      warm_d  = '0;
      try_d   = '0;
    end else begin
      unique case (state_q)
        S_WARM: begin
          cells_d = cells_step;
          if (warm_q == WARM_LAST) begin
            state_d = S_IDLE;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + 8'd1;
          end
        end
        S_IDLE: begin
          if (enable) cells_d = cells_step;
          if (req) begin
            state_d = S_DRAW;
            try_d   = '0;
          end
        end
        S_DRAW: begin
          cells_d = cells_step;
          if (in_range) begin
            data_d  = raw;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end else if (try_q == TRY_LAST) begin
            data_d  = raw & FB_MASK;
            dv_d    = 1'b1;
            to_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            try_d = try_q + 8'd1;
          end
        end
        default: begin
          state_d = S_WARM;
          warm_d  = '0;
          try_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_WARM;
      warm_q  <= '0;
      try_q   <= '0;
      cells_q <= seed_sub;
      data_q  <= '0;
      dv_q    <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      try_q   <= try_d;
      cells_q <= cells_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_random_lfsr_bank.sv
// tb_random_lfsr_bank: directed checks of random_lfsr_bank
// across four parameter sets sharing one clock and reset.
module tb_random_lfsr_bank;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetn;

  logic [7:0]  seeds0;
  logic        sl0, en0, req0, busy0, dv0, to0;
  logic [0:0]  data0;

  logic [63:0] seeds1;
  logic        sl1, en1, req1, busy1, dv1, to1;
  logic [7:0]  data1;

  logic [23:0] seeds2;
  logic        sl2, en2, req2, busy2, dv2, to2;
  logic [2:0]  data2;

  logic [15:0] seeds3;
  logic        sl3, en3, req3, busy3, dv3, to3;
  logic [1:0]  data3;

  random_lfsr_bank #(
    .CHANNELS(1), .LFSR_W(8), .WARMUP(1),
    .LIMIT(2), .MAX_TRIES(15)
  ) u0 (
    .clock(clock), .resetn(resetn), .seeds(seeds0),
    .seed_load(sl0), .enable(en0), .req(req0),
    .busy(busy0), .data(data0), .data_valid(dv0),
    .timeout(to0)
  );

  random_lfsr_bank u1 (
    .clock(clock), .resetn(resetn), .seeds(seeds1),
    .seed_load(sl1), .enable(en1), .req(req1),
    .busy(busy1), .data(data1), .data_valid(dv1),
    .timeout(to1)
  );

  random_lfsr_bank #(
    .CHANNELS(3), .LFSR_W(8), .WARMUP(1),
    .LIMIT(5), .MAX_TRIES(15)
  ) u2 (
    .clock(clock), .resetn(resetn), .seeds(seeds2),
    .seed_load(sl2), .enable(en2), .req(req2),
    .busy(busy2), .data(data2), .data_valid(dv2),
    .timeout(to2)
  );

  random_lfsr_bank #(
    .CHANNELS(2), .LFSR_W(8), .WARMUP(1),
    .LIMIT(2), .MAX_TRIES(1)
  ) u3 (
    .clock(clock), .resetn(resetn), .seeds(seeds3),
    .seed_load(sl3), .enable(en3), .req(req3),
    .busy(busy3), .data(data3), .data_valid(dv3),
    .timeout(to3)
  );

  int checks = 0;
  int errors = 0;
  int n;
  int dv_seen;
  logic [7:0] m [8];
  logic [7:0] exp_raw;
  logic [7:0] fr [4];

  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_load(input logic [63:0] s);
    for (int i = 0; i < 8; i++) begin
      m[i] = s[i*8 +: 8];
      if (m[i] == 8'h00) m[i] = 8'(i + 1);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 8; i++) m[i] = step8(m[i]);
  endtask

  function automatic logic [7:0] model_raw();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m[i][0];
    return r;
  endfunction

  task automatic count_warm();
    n = 0;
    dv_seen = 0;
    while (busy1 && n < 100) begin
      tick();
      n++;
      if (dv1) dv_seen++;
    end
  endtask

  initial begin
    resetn = 1'b0;
    seeds0 = 8'h01;
    seeds1 = 64'h0;
    seeds2 = 24'hC0C280;
    seeds3 = 16'h8080;
    {sl0, en0, req0} = '0;
    {sl1, en1, req1} = '0;
    {sl2, en2, req2} = '0;
    {sl3, en3, req3} = '0;
    tick();
    tick();

    check("rst_cell0", u0.cells_q[0], 8'h01);
    check("rst_busy0", busy0, 1'b1);
    check("zero_seed_c7", u1.cells_q[7], 8'h08);
    check("zero_seed_c0", u1.cells_q[0], 8'h01);
    check("rst_data1", data1, 8'h00);
    check("rst_busy1", busy1, 1'b1);
    check("rst_dv1", dv1, 1'b0);
    check("rst_to1", to1, 1'b0);

    resetn = 1'b1;
    count_warm();
    check("warm_len", n, 16);
    check("warm_no_dv", dv_seen, 0);
    check("warm_data1", data1, 8'h00);

    check("u0_after_warm", u0.cells_q[0], 8'h02);
    check("u0_busy_idle", busy0, 1'b0);
    fr[0] = 8'h04;
    fr[1] = 8'h08;
    fr[2] = 8'h11;
    fr[3] = 8'h23;
    en0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("u0_freerun", u0.cells_q[0], fr[k]);
    end
    en0 = 1'b0;

    model_load(64'h0);
    repeat (16) model_step();
    exp_raw = model_raw();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    check("draw_busy", busy1, 1'b1);
    check("draw_dv_early", dv1, 1'b0);
    tick();
    check("draw_dv", dv1, 1'b1);
    check("draw_data", data1, exp_raw);
    check("draw_to", to1, 1'b0);
    model_step();
    tick();
    check("draw_dv_pulse", dv1, 1'b0);
    check("draw_idle", busy1, 1'b0);
    check("draw_hold", data1, exp_raw);

    seeds1 = 64'h5AC301FF_008037E4;
    req1 = 1'b1;
    tick();
    check("abort_busy", busy1, 1'b1);
    sl1 = 1'b1;
    tick();
    sl1 = 1'b0;
    req1 = 1'b0;
    check("abort_no_dv", dv1, 1'b0);
    check("abort_data", data1, exp_raw);
    check("abort_busy2", busy1, 1'b1);
    count_warm();
    check("abort_warm_len", n, 16);
    check("abort_no_dv2", dv_seen, 0);
    tick();
    check("abort_req_drop", busy1, 1'b0);
    check("abort_data2", data1, exp_raw);

    model_load(seeds1);
    repeat (16) model_step();
    exp_raw = model_raw();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    check("reseed_dv", dv1, 1'b1);
    check("reseed_data", data1, exp_raw);

    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    check("rej_busy", busy2, 1'b1);
    tick();
    check("rej_dv1", dv2, 1'b0);
    tick();
    check("rej_dv2", dv2, 1'b0);
    tick();
    check("rej_dv3", dv2, 1'b1);
    check("rej_data", data2, 3'd2);
    check("rej_to", to2, 1'b0);

    req3 = 1'b1;
    tick();
    req3 = 1'b0;
    check("fb_dv_early", dv3, 1'b0);
    tick();
    check("fb_dv", dv3, 1'b1);
    check("fb_data", data3, 2'd1);
    check("fb_to", to3, 1'b1);
    tick();
    check("fb_to_pulse", to3, 1'b0);
    check("fb_idle", busy3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
